// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: load-use stalls, taken-branch flushes,
// data-memory wait freeze with a sticky timeout, and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_access_i,
  input  logic             dm_ready_i,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             freeze_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_mwait;
  logic              w_lu;
  logic              w_do_branch;
  logic              w_do_lu;

  assign w_mwait = mem_access_i & ~dm_ready_i;
  assign w_lu    = idex_memread_i & (idex_rt_i != 5'd0) &
                   ((idex_rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)));

  assign timeout_o   = (r_state == ST_ERR);
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

  // Next state and Mealy control outputs; priority ERR > mwait > branch > load-use > normal
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    pc_write_o     = 1'b1;
    pc_src_o       = 1'b0;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    exmem_flush_o  = 1'b0;
    freeze_o       = 1'b0;
    w_do_branch    = 1'b0;
    w_do_lu        = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (w_mwait) begin
          w_state_nxt    = ST_WAIT;
          w_wait_cnt_nxt = '0;
        end
      end
      ST_WAIT: begin
        if (dm_ready_i) begin
          w_state_nxt = ST_RUN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      ST_ERR: begin
        w_state_nxt = ST_ERR;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    if (rst_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
    end else if (r_state == ST_ERR) begin
      freeze_o     = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else if (w_mwait) begin
      freeze_o     = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else if (branch_taken_i) begin
      // Any coincident load-use belongs to a wrong-path consumer and is dropped
      pc_src_o      = 1'b1;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      exmem_flush_o = 1'b1;
      w_do_branch   = 1'b1;
    end else if (w_lu) begin
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      idex_flush_o = 1'b1;
      w_do_lu      = 1'b1;
    end
  end

  // State register and saturating performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_do_lu && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_do_branch && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default and MAX_WAIT=4/CNT_W=2) driven in lockstep and
// checked every cycle against a rule-level model, plus directed literal expectations.
module tb_pipe_hazard_ctrl;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i;
  logic [4:0] ifid_rs_i;
  logic [4:0] ifid_rt_i;
  logic       ifid_uses_rt_i;
  logic       idex_memread_i;
  logic [4:0] idex_rt_i;
  logic       branch_taken_i;
  logic       mem_access_i;
  logic       dm_ready_i;

  logic        a_pcw, a_src, a_ifw, a_iff, a_idf, a_exf, a_frz, a_to;
  logic [15:0] a_stall, a_flush;
  logic        b_pcw, b_src, b_ifw, b_iff, b_idf, b_exf, b_frz, b_to;
  logic [1:0]  b_stall, b_flush;

  pipe_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(16)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .ifid_uses_rt_i(ifid_uses_rt_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .branch_taken_i(branch_taken_i), .mem_access_i(mem_access_i), .dm_ready_i(dm_ready_i),
    .pc_write_o(a_pcw), .pc_src_o(a_src), .ifid_write_o(a_ifw), .ifid_flush_o(a_iff),
    .idex_flush_o(a_idf), .exmem_flush_o(a_exf), .freeze_o(a_frz), .timeout_o(a_to),
    .stall_cnt_o(a_stall), .flush_cnt_o(a_flush)
  );

  pipe_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(2)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .ifid_rs_i(ifid_rs_i), .ifid_rt_i(ifid_rt_i),
    .ifid_uses_rt_i(ifid_uses_rt_i), .idex_memread_i(idex_memread_i), .idex_rt_i(idex_rt_i),
    .branch_taken_i(branch_taken_i), .mem_access_i(mem_access_i), .dm_ready_i(dm_ready_i),
    .pc_write_o(b_pcw), .pc_src_o(b_src), .ifid_write_o(b_ifw), .ifid_flush_o(b_iff),
    .idex_flush_o(b_idf), .exmem_flush_o(b_exf), .freeze_o(b_frz), .timeout_o(b_to),
    .stall_cnt_o(b_stall), .flush_cnt_o(b_flush)
  );

  // {pc_write, pc_src, ifid_write, ifid_flush, idex_flush, exmem_flush, freeze, timeout}
  logic [7:0] ctrl_act [2];
  int         stall_act [2];
  int         flush_act [2];
  always_comb begin
    ctrl_act[0]  = {a_pcw, a_src, a_ifw, a_iff, a_idf, a_exf, a_frz, a_to};
    ctrl_act[1]  = {b_pcw, b_src, b_ifw, b_iff, b_idf, b_exf, b_frz, b_to};
    stall_act[0] = int'(a_stall);
    stall_act[1] = int'(b_stall);
    flush_act[0] = int'(a_flush);
    flush_act[1] = int'(b_flush);
  end

  // Rule-level model state per instance
  bit m_err   [2];
  bit m_wait  [2];
  int m_wcnt  [2];
  int m_stall [2];
  int m_flush [2];
  int maxw    [2] = '{16, 4};
  int cmax    [2] = '{65535, 3};

  int n_chk  = 0;
  int n_fail = 0;

  function automatic bit f_lu();
    return idex_memread_i && (idex_rt_i != 5'd0) &&
           ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
  endfunction

  function automatic bit f_mwait();
    return mem_access_i && !dm_ready_i;
  endfunction

  function automatic logic [7:0] model_ctrl(input int k);
    logic [7:0] v;
    if (rst_i)                v = {7'b0001110, m_err[k]};
    else if (m_err[k])        v = 8'b0000_0011;
    else if (f_mwait())       v = 8'b0000_0010;
    else if (branch_taken_i)  v = 8'b1111_1100;
    else if (f_lu())          v = 8'b0000_1000;
    else                      v = 8'b1010_0000;
    return v;
  endfunction

  task automatic model_update(input int k);
    if (rst_i) begin
      m_err[k] = 0; m_wait[k] = 0; m_wcnt[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end else if (!m_err[k]) begin
      if (!f_mwait() && branch_taken_i) begin
        if (m_flush[k] < cmax[k]) m_flush[k]++;
      end else if (!f_mwait() && f_lu()) begin
        if (m_stall[k] < cmax[k]) m_stall[k]++;
      end
      if (!m_wait[k]) begin
        if (f_mwait()) begin
          m_wait[k] = 1; m_wcnt[k] = 0;
        end
      end else if (dm_ready_i) begin
        m_wait[k] = 0;
      end else if (m_wcnt[k] == maxw[k] - 1) begin
        m_wait[k] = 0; m_err[k] = 1;
      end else begin
        m_wcnt[k]++;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    rst_i = 0; ifid_rs_i = 5'd1; ifid_rt_i = 5'd2; ifid_uses_rt_i = 0;
    idex_memread_i = 0; idex_rt_i = 5'd3; branch_taken_i = 0; mem_access_i = 0; dm_ready_i = 1;
  endtask

  // Move to the falling edge and compare both instances against the model
  task automatic settle();
    @(negedge clk_i);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ctrl[%0d]", k), int'(ctrl_act[k]), int'(model_ctrl(k)));
      chk($sformatf("stall_cnt[%0d]", k), stall_act[k], m_stall[k]);
      chk($sformatf("flush_cnt[%0d]", k), flush_act[k], m_flush[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic do_reset();
    idle(); rst_i = 1; settle(); tick(); rst_i = 0;
  endtask

  task automatic set_lu();
    idex_memread_i = 1; idex_rt_i = 5'd8; ifid_rs_i = 5'd8;
  endtask

  int rdy_pct;

  initial begin
    idle();
    rst_i = 1;
    tick();
    // Reset values while rst_i is held
    settle();
    chk("rst pc_write", int'(a_pcw), 0);
    chk("rst ifid_write", int'(a_ifw), 0);
    chk("rst idex_flush", int'(a_idf), 1);
    chk("rst freeze", int'(a_frz), 0);
    tick();
    rst_i = 0;
    settle();
    chk("post-rst timeout", int'(a_to), 0);
    chk("post-rst stall_cnt", int'(a_stall), 0);
    tick();

    // Load-use: one stall, then normal flow
    set_lu(); settle();
    chk("lu pc_write", int'(a_pcw), 0);
    chk("lu ifid_write", int'(a_ifw), 0);
    chk("lu idex_flush", int'(a_idf), 1);
    tick();
    idex_memread_i = 0; settle();
    chk("lu next pc_write", int'(a_pcw), 1);
    chk("lu stall_cnt", int'(a_stall), 1);
    tick();
    set_lu(); idex_rt_i = 5'd0; ifid_rs_i = 5'd0; settle();
    chk("lu r0 pc_write", int'(a_pcw), 1);
    chk("lu r0 idex_flush", int'(a_idf), 0);
    tick();
    idle(); idex_memread_i = 1; idex_rt_i = 5'd5; ifid_rt_i = 5'd5; ifid_uses_rt_i = 0; settle();
    chk("lu rt unused", int'(a_idf), 0);
    tick();
    ifid_uses_rt_i = 1; settle();
    chk("lu rt used", int'(a_idf), 1);
    tick();

    // Branch with a coincident load-use
    do_reset();
    set_lu(); branch_taken_i = 1; settle();
    chk("br pc_src", int'(a_src), 1);
    chk("br pc_write", int'(a_pcw), 1);
    chk("br flushes", int'({a_iff, a_idf, a_exf}), 7);
    tick();
    idle(); settle();
    chk("br flush_cnt", int'(a_flush), 1);
    chk("br stall_cnt", int'(a_stall), 0);
    tick();

    // Memory wait of three cycles
    mem_access_i = 1; dm_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mw freeze", int'(a_frz), 1);
      chk("mw pc_write", int'(a_pcw), 0);
      tick();
    end
    dm_ready_i = 1; settle();
    chk("mw done freeze", int'(a_frz), 0);
    chk("mw done pc_write", int'(a_pcw), 1);
    tick();
    idle(); settle();
    chk("mw timeout", int'(a_to), 0);
    tick();

    // Timeout on the MAX_WAIT=4 instance
    do_reset();
    mem_access_i = 1; dm_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("to early", int'(b_to), 0);
      tick();
    end
    settle();
    chk("to tripped", int'(b_to), 1);
    chk("to freeze", int'(b_frz), 1);
    tick();
    dm_ready_i = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("to sticky", int'(b_to), 1);
      chk("to pc_write", int'(b_pcw), 0);
      tick();
    end
    idle(); rst_i = 1; settle();
    chk("to rst pc_write", int'(b_pcw), 0);
    chk("to rst freeze", int'(b_frz), 0);
    tick();
    rst_i = 0; settle();
    chk("to cleared", int'(b_to), 0);
    chk("to run pc_write", int'(b_pcw), 1);
    tick();

    // Counter saturation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_lu(); settle(); tick();
      idle(); settle(); tick();
    end
    chk("sat b stall_cnt", int'(b_stall), 3);
    chk("sat a stall_cnt", int'(a_stall), 5);

    // Reset in the middle of a wait
    mem_access_i = 1; dm_ready_i = 0;
    settle(); tick(); settle(); tick();
    rst_i = 1; settle();
    chk("rmw pc_write", int'(a_pcw), 0);
    chk("rmw freeze", int'(a_frz), 0);
    chk("rmw exmem_flush", int'(a_exf), 1);
    tick();
    idle(); settle();
    chk("rmw a stall_cnt", int'(a_stall), 0);
    chk("rmw b stall_cnt", int'(b_stall), 0);
    chk("rmw freeze after", int'(a_frz), 0);
    tick();

    // Randomized traffic
    rdy_pct = 70;
    for (int i = 0; i < 4000; i++) begin
      if (i % 256 == 0) rdy_pct = int'($urandom_range(20, 95));
      rst_i          = ($urandom_range(0, 199) == 0);
      idex_memread_i = $urandom_range(0, 1) == 1;
      idex_rt_i      = 5'($urandom_range(0, 3));
      ifid_rs_i      = 5'($urandom_range(0, 3));
      ifid_rt_i      = 5'($urandom_range(0, 3));
      ifid_uses_rt_i = $urandom_range(0, 1) == 1;
      branch_taken_i = ($urandom_range(0, 9) == 0);
      mem_access_i   = ($urandom_range(0, 9) < 4);
      dm_ready_i     = (int'($urandom_range(0, 99)) < rdy_pct);
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
